data_bus_ctrl: RTL and testbench

Data-side memory/peripheral controller directly downstream of the RV32I core's load/store port. Consumes the core's `addr`/`dataBusOut`/`wrEn`/`rdEn`/`RamMode` and decodes each access to a byte-enabled synchronous data RAM or a UART register window. Realigns and extends load data, and returns it on `dataBusIn` with the fixed two-cycle latency the core's write-back stage expects. Buffers UART transmit bytes in a small FIFO so that stores never stall the core.

---
 rtl/data_bus_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_data_bus_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_ctrl.sv
// data_bus_ctrl: data-side load/store controller for the RV32I core.
// Decodes each core access to a byte-enabled synchronous RAM, a UART register
// window, or an unmapped hole. Load results of every target come back through
// one two-stage pipe, so load latency is always two cycles.
// UART window layout:
//   +0 store  pushes a TX byte
//   +0 load   reads the RX byte
//   +4 load   reads status {ovf, rx_valid, txf_full}
// Ports:
//   clk, rstB                 clock, asynchronous active-low reset
//   clkEn, addr, dataBusOut,  core request (RamMode = {byte, half, word, unsigned})
//   wrEn, rdEn, RamMode
//   dataBusIn, dataBusInEn    load result and its one-cycle valid strobe
//   ram_addr/we/wdata/rdata   data RAM (1-cycle read, read-after-write across cycles)
//   uart_tx_*                 TX FIFO head with valid/ready handshake
//   uart_rx_*                 RX byte, consumed by uart_rx_pop
//   misalign_err              sticky misaligned-access flag
module data_bus_ctrl #(
    parameter int          RAM_AW    = 12,
    parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
    parameter logic [31:0] UART_BASE = 32'h1000_0000,
    parameter int          TXF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rstB,
    input  logic              clkEn,
    input  logic [31:0]       addr,
    input  logic [31:0]       dataBusOut,
    input  logic              wrEn,
    input  logic              rdEn,
    input  logic [3:0]        RamMode,
    output logic [31:0]       dataBusIn,
    output logic              dataBusInEn,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [3:0]        ram_we,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [7:0]        uart_tx_data,
    output logic              uart_tx_valid,
    input  logic              uart_tx_ready,
    input  logic [7:0]        uart_rx_data,
    input  logic              uart_rx_valid,
    output logic              uart_rx_pop,
    output logic              misalign_err
);
    localparam int PW = $clog2(TXF_DEPTH);
    localparam logic [PW:0] PTR_ONE = 1;

    // request decode
    logic m_byte, m_half, m_word, mis;
    logic st_req, ld_req, hit_ram, hit_uart;
    logic push_req, push, pop, stat_ld, rx_ld;
    logic empty, full;
    logic [3:0] we_raw;

    assign m_byte   = RamMode[3];
    assign m_half   = RamMode[2] & ~RamMode[3];
    assign m_word   = RamMode[1] & ~RamMode[2] & ~RamMode[3];
    assign mis      = (m_half & addr[0]) | (m_word & (addr[1:0] != 2'b00));
    // a simultaneous wrEn/rdEn is a store
    assign st_req   = clkEn & wrEn;
    assign ld_req   = clkEn & rdEn & ~wrEn;
    assign hit_ram  = addr[31:RAM_AW+2] == RAM_BASE[31:RAM_AW+2];
    assign hit_uart = (addr[31:3] == UART_BASE[31:3]) & ~hit_ram;
    assign push_req = st_req & hit_uart & ~addr[2] & ~mis;
    assign rx_ld    = ld_req & hit_uart & ~addr[2] & ~mis;
    assign stat_ld  = ld_req & hit_uart & addr[2] & ~mis;

    // RAM write path, combinational in the request cycle
    assign ram_addr = addr[RAM_AW+1:2];
    always_comb begin
        we_raw    = 4'h0;
        ram_wdata = dataBusOut;
        if (m_byte)      ram_wdata = {4{dataBusOut[7:0]}};
        else if (m_half) ram_wdata = {2{dataBusOut[15:0]}};
        if (st_req & hit_ram & ~mis) begin
            if (m_byte)      we_raw = 4'b0001 << addr[1:0];
            else if (m_half) we_raw = 4'b0011 << addr[1:0];
            else if (m_word) we_raw = 4'hF;
        end
    end
    // the strobes are combinational, so they are forced low while reset is held
    assign ram_we      = rstB ? we_raw : 4'h0;
    assign uart_rx_pop = rstB & rx_ld & uart_rx_valid;

    // TX FIFO, pointers carry one extra wrap bit to tell full from empty
    logic [PW:0]                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [TXF_DEPTH-1:0][7:0]   mem_q, mem_d;
    logic                        ovf_q, ovf_d, mis_err_q, mis_err_d;

    assign empty = wr_ptr_q == rd_ptr_q;
    assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign pop   = ~empty & uart_tx_ready;
    // a pop in the same cycle frees the slot the push needs
    assign push  = push_req & (~full | pop);

    assign uart_tx_valid = ~empty;
    assign uart_tx_data  = mem_q[rd_ptr_q[PW-1:0]];
    assign misalign_err  = mis_err_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        if (push) begin
            mem_d[wr_ptr_q[PW-1:0]] = dataBusOut[7:0];
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (stat_ld) ovf_d = 1'b0;
        if (push_req & ~push) ovf_d = 1'b1;
        mis_err_d = mis_err_q | ((st_req | ld_req) & mis);
    end

    // load pipe: stage 1 holds the access, stage 2 the realigned result.
    // Misaligned and non-RAM loads are folded into s1_data (already final),
    // so s1_ram_q alone selects the RAM lane path.
    logic        s1_vld_q, s1_vld_d, s1_ram_q, s1_ram_d;
    logic [1:0]  s1_off_q, s1_off_d;
    logic [2:0]  s1_mode_q, s1_mode_d;  // {byte, half, unsigned}
    logic [31:0] s1_data_q, s1_data_d;
    logic        en_q, en_d;
    logic [31:0] dbin_q, dbin_d, lane;

    always_comb begin
        s1_vld_d  = ld_req;
        s1_ram_d  = hit_ram & ~mis;
        s1_off_d  = addr[1:0];
        s1_mode_d = {m_byte, m_half, RamMode[0]};
        s1_data_d = 32'h0;
        if (rx_ld & uart_rx_valid) s1_data_d = {24'h0, uart_rx_data};
        if (stat_ld)               s1_data_d = {29'h0, ovf_q, uart_rx_valid, full};

        lane   = ram_rdata >> {s1_off_q, 3'b000};
        en_d   = s1_vld_q;
        dbin_d = dbin_q;
        if (s1_vld_q) begin
            if (!s1_ram_q)        dbin_d = s1_data_q;
            else if (s1_mode_q[2]) dbin_d = s1_mode_q[0] ? {24'h0, lane[7:0]}
                                                         : {{24{lane[7]}}, lane[7:0]};
            else if (s1_mode_q[1]) dbin_d = s1_mode_q[0] ? {16'h0, lane[15:0]}
                                                         : {{16{lane[15]}}, lane[15:0]};
            else                   dbin_d = lane;
        end
    end

    assign dataBusIn   = dbin_q;
    assign dataBusInEn = en_q;

    always_ff @(posedge clk or negedge rstB) begin
        if (!rstB) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            mem_q     <= '0;
            ovf_q     <= 1'b0;
            mis_err_q <= 1'b0;
            s1_vld_q  <= 1'b0;
            s1_ram_q  <= 1'b0;
            s1_off_q  <= 2'b00;
            s1_mode_q <= 3'b000;
            s1_data_q <= 32'h0;
            en_q      <= 1'b0;
            dbin_q    <= 32'h0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            mem_q     <= mem_d;
            ovf_q     <= ovf_d;
            mis_err_q <= mis_err_d;
            s1_vld_q  <= s1_vld_d;
            s1_ram_q  <= s1_ram_d;
            s1_off_q  <= s1_off_d;
            s1_mode_q <= s1_mode_d;
            s1_data_q <= s1_data_d;
            en_q      <= en_d;
            dbin_q    <= dbin_d;
        end
    end
endmodule

// File: tb/tb_data_bus_ctrl.sv
// Bench for data_bus_ctrl: a queue/array reference model of the spec rules,
// a per-cycle compare process, and directed vectors with literal expectations.
module tb_data_bus_ctrl;
    localparam logic [3:0] MB = 4'b1000, MH = 4'b0100, MW = 4'b0010, MU = 4'b0001;
    localparam logic [31:0] UB = 32'h1000_0000;

    logic clk = 0, rstB = 0, clkEn = 0, wrEn = 0, rdEn = 0;
    logic [31:0] addr = 0, dataBusOut = 0, dataBusIn, ram_wdata, ram_rdata = 0;
    logic [3:0] RamMode = 0, ram_we;
    logic dataBusInEn, uart_tx_valid, uart_tx_ready = 0, uart_rx_valid = 0, uart_rx_pop, misalign_err;
    logic [11:0] ram_addr;
    logic [7:0] uart_tx_data, uart_rx_data = 0;

    always #5 clk = ~clk;

    data_bus_ctrl dut (
        .clk(clk), .rstB(rstB), .clkEn(clkEn), .addr(addr), .dataBusOut(dataBusOut),
        .wrEn(wrEn), .rdEn(rdEn), .RamMode(RamMode), .dataBusIn(dataBusIn),
        .dataBusInEn(dataBusInEn), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .uart_tx_data(uart_tx_data),
        .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
        .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid),
        .uart_rx_pop(uart_rx_pop), .misalign_err(misalign_err)
    );

    // the RAM device attached to the DUT
    logic [31:0] dev [0:4095];
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (ram_we[i]) dev[ram_addr][i*8 +: 8] <= ram_wdata[i*8 +: 8];
        ram_rdata <= dev[ram_addr];
    end

    int npass = 0, ntotal = 0;
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        ntotal++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    endtask

    // reference model
    typedef struct { int due; logic [31:0] val; } exp_t;
    exp_t exp_q[$];
    logic [7:0] m_q[$];
    logic [31:0] ref_mem [0:4095];
    logic m_ovf = 0, m_mis = 0;
    int cyc = 0;

    function automatic logic [31:0] ld_val(input logic [31:0] w, input logic [1:0] a, input logic [3:0] m);
        logic [7:0] b;
        logic [15:0] h;
        b = w[int'(a)*8 +: 8];
        h = w[int'(a[1])*16 +: 16];
        if (m[3]) return m[0] ? {24'h0, b} : {{24{b[7]}}, b};
        if (m[2]) return m[0] ? {16'h0, h} : {{16{h[15]}}, h};
        return w;
    endfunction

    always @(posedge clk or negedge rstB) begin
        if (!rstB) begin
            exp_q.delete(); m_q.delete(); m_ovf = 0; m_mis = 0;
        end else begin
            logic pop, push, ram, uart, mis;
            logic [31:0] v;
            logic [11:0] wa;
            cyc++;
            pop  = (m_q.size() != 0) && uart_tx_ready;
            push = 0;
            ram  = addr[31:14] == 18'h0;
            uart = addr[31:3] == UB[31:3];
            mis  = (RamMode[2] && !RamMode[3] && addr[0]) ||
                   (RamMode == MW && addr[1:0] != 0);
            wa   = addr[13:2];
            if (clkEn && (wrEn || rdEn)) begin
                if (mis) m_mis = 1;
                if (wrEn) begin
                    if (!mis && ram) begin
                        if (RamMode[3]) ref_mem[wa][int'(addr[1:0])*8 +: 8] = dataBusOut[7:0];
                        else if (RamMode[2]) ref_mem[wa][int'(addr[1])*16 +: 16] = dataBusOut[15:0];
                        else ref_mem[wa] = dataBusOut;
                    end else if (!mis && uart && !addr[2]) begin
                        if (m_q.size() == 4 && !pop) m_ovf = 1;
                        else push = 1;
                    end
                end else begin
                    v = 0;
                    if (!mis && ram) v = ld_val(ref_mem[wa], addr[1:0], RamMode);
                    else if (!mis && uart && addr[2]) begin
                        v = {29'h0, m_ovf, uart_rx_valid, m_q.size() == 4};
                        m_ovf = 0;
                    end else if (!mis && uart && uart_rx_valid) v = {24'h0, uart_rx_data};
                    exp_q.push_back('{due: cyc + 1, val: v});
                end
            end
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back(dataBusOut[7:0]);
        end
    end

    // per-cycle compare against the model
    logic [31:0] last = 0;
    logic [31:0] strobed[$];
    logic [7:0] drained[$];
    always @(posedge clk) begin
        if (rstB && uart_tx_valid && uart_tx_ready) drained.push_back(uart_tx_data);
        #1;
        if (!rstB) last = 0;
        if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
            chk("strobe", {31'h0, dataBusInEn}, 1);
            chk("load_data", dataBusIn, exp_q[0].val);
            last = exp_q[0].val;
            strobed.push_back(dataBusIn);
            void'(exp_q.pop_front());
        end else begin
            chk("no_strobe", {31'h0, dataBusInEn}, 0);
            chk("data_hold", dataBusIn, last);
        end
        chk("tx_valid", {31'h0, uart_tx_valid}, {31'h0, m_q.size() != 0});
        if (m_q.size() != 0) chk("tx_data", {24'h0, uart_tx_data}, {24'h0, m_q[0]});
        chk("misalign", {31'h0, misalign_err}, {31'h0, m_mis});
    end

    task automatic acc(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        clkEn = 1; wrEn = w; rdEn = !w; addr = a; dataBusOut = d; RamMode = m;
    endtask
    task automatic idle(input int n);
        repeat (n) begin @(negedge clk); wrEn = 0; rdEn = 0; clkEn = 1; end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin dev[i] = 0; ref_mem[i] = 0; end
        // reset state
        idle(3);
        #1;
        chk("rst_dbin", dataBusIn, 0);
        chk("rst_en", {31'h0, dataBusInEn}, 0);
        chk("rst_txv", {31'h0, uart_tx_valid}, 0);
        chk("rst_mis", {31'h0, misalign_err}, 0);
        @(negedge clk); rstB = 1;

        // word store/load and exact latency
        acc(1, 32'h10, 32'hDEADBEEF, MW); #1;
        chk("st_word_we", {28'h0, ram_we}, 32'hF);
        chk("st_word_wd", ram_wdata, 32'hDEADBEEF);
        acc(0, 32'h10, 0, MW);
        idle(1);
        chk("lat_t1", {31'h0, dataBusInEn}, 0);
        idle(1);
        chk("lat_t2_en", {31'h0, dataBusInEn}, 1);
        chk("lat_t2_data", dataBusIn, 32'hDEADBEEF);
        idle(1);
        chk("lat_t3_en", {31'h0, dataBusInEn}, 0);
        chk("lat_t3_hold", dataBusIn, 32'hDEADBEEF);

        // sign/zero extension, back-to-back
        acc(1, 32'h10, 32'h80FF7F01, MW);
        strobed.delete();
        acc(0, 32'h13, 0, MB);
        acc(0, 32'h12, 0, MH | MU);
        idle(3);
        chk("b2b_cnt", strobed.size(), 2);
        chk("ld_sbyte", strobed[0], 32'hFFFFFF80);
        chk("ld_uhalf", strobed[1], 32'h000080FF);

        // misalignment, sub-word stores, unmapped, clkEn gating
        acc(1, 32'h11, 32'hABCD, MH); #1;
        chk("mis_st_we", {28'h0, ram_we}, 0);
        idle(1);
        chk("mis_flag", {31'h0, misalign_err}, 1);
        strobed.delete();
        acc(0, 32'h12, 0, MW);
        acc(1, 32'h15, 32'hA5, MB); #1;
        chk("st_byte_we", {28'h0, ram_we}, 32'h2);
        chk("st_byte_wd", ram_wdata, 32'hA5A5A5A5);
        acc(1, 32'h16, 32'h1234, MH); #1;
        chk("st_half_we", {28'h0, ram_we}, 32'hC);
        acc(0, 32'h14, 0, MW);
        acc(1, 32'h2000_0000, 32'h55, MW); #1;
        chk("unmap_we", {28'h0, ram_we}, 0);
        acc(0, 32'h2000_0000, 0, MW);
        acc(0, 32'h10, 0, MW); clkEn = 0;
        idle(3);
        chk("mis_cnt", strobed.size(), 3);
        chk("mis_ld", strobed[0], 0);
        chk("sub_words", strobed[1], 32'h1234A500);
        chk("unmap_ld", strobed[2], 0);

        // TX overflow, status clear-on-read, drain order
        for (int i = 0; i < 5; i++) acc(1, UB, 32'h11 + i, MB);
        strobed.delete();
        acc(0, UB + 4, 0, MW);
        acc(0, UB + 4, 0, MW);
        idle(3);
        chk("stat_ovf", strobed[0], 32'h5);
        chk("stat_clr", strobed[1], 32'h1);
        drained.delete();
        uart_tx_ready = 1;
        idle(6);
        uart_tx_ready = 0;
        chk("drain_cnt", drained.size(), 4);
        for (int i = 0; i < 4; i++) chk("drain_byte", {24'h0, drained[i]}, 32'h11 + i);

        // RX data read and pop
        strobed.delete();
        uart_rx_data = 8'h5A; uart_rx_valid = 1;
        acc(0, UB, 0, MW); #1;
        chk("rx_pop", {31'h0, uart_rx_pop}, 1);
        acc(0, UB, 0, MW); uart_rx_valid = 0; #1;
        chk("rx_nopop", {31'h0, uart_rx_pop}, 0);
        idle(3);
        chk("rx_data", strobed[0], 32'h5A);
        chk("rx_empty", strobed[1], 0);

        // full FIFO with simultaneous pop and push
        for (int i = 0; i < 4; i++) acc(1, UB, 32'h21 + i, MB);
        acc(1, UB, 32'h25, MB); uart_tx_ready = 1;
        strobed.delete();
        acc(0, UB + 4, 0, MW); uart_tx_ready = 0;
        idle(3);
        chk("full_pp_stat", strobed[0], 32'h1);
        chk("full_pp_head", {24'h0, uart_tx_data}, 32'h22);

        // reset in the middle of a load
        acc(0, 32'h10, 0, MW);
        @(negedge clk);
        rstB = 0; uart_rx_valid = 1;
        wrEn = 1; rdEn = 0; addr = 32'h10; RamMode = MW; #1;
        chk("rst_we", {28'h0, ram_we}, 0);
        chk("rst_mid_dbin", dataBusIn, 0);
        chk("rst_mid_en", {31'h0, dataBusInEn}, 0);
        chk("rst_mid_txv", {31'h0, uart_tx_valid}, 0);
        chk("rst_mid_mis", {31'h0, misalign_err}, 0);
        wrEn = 0; rdEn = 1; addr = UB; #1;
        chk("rst_pop", {31'h0, uart_rx_pop}, 0);
        idle(3);
        rstB = 1; uart_rx_valid = 0;
        idle(4);
        chk("pending", exp_q.size(), 0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
